// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer width and the master FSM state set.
package spi_pkg;

  localparam int SPI_WIDTH    = 8;
  localparam int HALF_PERIODS = 2 * SPI_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_GAP
  } spiState_e;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI bus signals of the SPI master, bundled for port use.
interface spi_master_if;
  import spi_pkg::*;

  logic                 start;
  logic [SPI_WIDTH-1:0] data_to_send;
  logic                 busy;
  logic [SPI_WIDTH-1:0] received_data;
  logic                 data_valid;
  logic                 SCLK;
  logic                 MOSI;
  logic                 MISO;
  logic                 SS;

  modport master (
    input  start, data_to_send, MISO,
    output busy, received_data, data_valid, SCLK, MOSI, SS
  );

  modport slave (
    output start, data_to_send, MISO,
    input  busy, received_data, data_valid, SCLK, MOSI, SS
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high in every CLK_DIV-th cycle after a clear.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Count cycles since the last clear, wrapping after each tick.
  always_ff @(posedge CLK) begin
    if (RESET || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one 8-bit MSB-first transfer per accepted start, all outputs registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic          CLK,
  input logic          RESET,
  spi_master_if.master bus
);

  spiState_e state_q, state_d;

  logic [SPI_WIDTH-1:0] txShift_q, txShift_d;
  logic [SPI_WIDTH-1:0] rxShift_q, rxShift_d;
  logic [SPI_WIDTH-1:0] rxData_q, rxData_d;
  logic [3:0]           halfCnt_q, halfCnt_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ss_q, ss_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  logic tick;
  logic clear;

  // The divider restarts on every state change so each state lasts whole half-periods.
  assign clear = (state_d != state_q);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clkDiv (
    .CLK  (CLK),
    .RESET(RESET),
    .clear(clear),
    .tick (tick)
  );

  assign bus.SS            = ss_q;
  assign bus.SCLK          = sclk_q;
  assign bus.MOSI          = mosi_q;
  assign bus.busy          = busy_q;
  assign bus.data_valid    = valid_q;
  assign bus.received_data = rxData_q;

  // State register; reset aborts any transfer without touching data_valid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; outputs are derived from the state being entered.
  always_comb begin
    state_d   = state_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    halfCnt_d = halfCnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_LEAD;
          txShift_d = bus.data_to_send;
          mosi_d    = bus.data_to_send[SPI_WIDTH-1];
          rxShift_d = '0;
          halfCnt_d = '0;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d   = ST_XFER;
          sclk_d    = 1'b1;
          rxShift_d = {rxShift_q[SPI_WIDTH-2:0], bus.MISO};
          halfCnt_d = '0;
        end
      end
      ST_XFER: begin
        if (tick) begin
          halfCnt_d = halfCnt_q + 4'd1;
          if (!halfCnt_q[0]) begin
            sclk_d = 1'b0;
            if (halfCnt_q != 4'(HALF_PERIODS - 2)) begin
              txShift_d = txShift_q << 1;
              mosi_d    = txShift_q[SPI_WIDTH-2];
            end
          end else if (halfCnt_q == 4'(HALF_PERIODS - 1)) begin
            state_d = ST_TRAIL;
          end else begin
            sclk_d    = 1'b1;
            rxShift_d = {rxShift_q[SPI_WIDTH-2:0], bus.MISO};
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d  = ST_GAP;
          rxData_d = rxShift_q;
          valid_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ss_d   = !((state_d == ST_LEAD) || (state_d == ST_XFER) || (state_d == ST_TRAIL));
    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      halfCnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      halfCnt_q <= halfCnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in CLK cycles; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one 8-bit transfer.
REQ-005 SHALL have port data_to_send  input  8  byte to shift out, MSB first.
REQ-006 SHALL have port busy  output  1  high while a transfer or the post-transfer gap is in progress.
REQ-007 SHALL have port received_data  output  8  last byte shifted in from MISO.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when received_data updates.
REQ-009 SHALL have port SCLK  output  1  SPI clock, mode 0, idle low.
REQ-010 SHALL have port MOSI  output  1  serial data to slave.
REQ-011 SHALL have port MISO  input  1  serial data from slave.
REQ-012 SHALL have port SS  output  1  slave select, active low.

Function
REQ-013 SHALL implement the FSM IDLE -> LEAD -> XFER -> TRAIL -> GAP -> IDLE.
REQ-014 SHALL generate an internal tick every CLK_DIV cycles from a counter that is cleared on every state entry; all SCLK/MOSI/MISO activity SHALL occur only on ticks.
REQ-015 IDLE: SS=1, SCLK=0, busy=0; start=1 SHALL be accepted in that cycle, data_to_send SHALL be captured, and the FSM SHALL enter LEAD.
REQ-016 LEAD: from the cycle after acceptance, SS=0 and MOSI=bit 7; duration CLK_DIV cycles.
REQ-017 XFER: SHALL produce 16 half-periods of CLK_DIV cycles each, starting with SCLK rising; MISO SHALL be sampled into the shift register on the tick that drives SCLK high.
REQ-018 XFER: MOSI SHALL advance to the next lower bit on the tick that drives SCLK low, except after the 8th falling edge, where MOSI holds bit 0.
REQ-019 TRAIL: SS=0, SCLK=0; duration CLK_DIV cycles.
REQ-020 On TRAIL exit, SS SHALL go high, received_data SHALL load the 8 sampled bits (first sample in bit 7), and data_valid SHALL pulse for exactly 1 cycle.
REQ-021 GAP: SS=1, busy=1; duration CLK_DIV cycles, which is the minimum SS-high time between transfers.
REQ-022 SS SHALL be low for exactly 18*CLK_DIV cycles per transfer, and exactly 8 SCLK rising edges SHALL occur.
REQ-023 start asserted outside IDLE SHALL be ignored and not queued; start held high SHALL cause back-to-back transfers separated by exactly CLK_DIV SS-high cycles in GAP plus 1 IDLE cycle.
REQ-024 data_to_send changes after acceptance SHALL NOT affect the transfer in progress.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 While RESET=1, outputs SHALL be SS=1, SCLK=0, MOSI=0, busy=0, data_valid=0, and received_data=0x00; state SHALL be IDLE and counters 0.
REQ-027 RESET SHALL take priority over start; a reset during any state SHALL abort the transfer on the next edge with no data_valid pulse and no update of received_data.

Structure
REQ-028 A shared package spi_pkg SHALL hold SPI_WIDTH=8 and the FSM state enumeration; spi_slave SHALL be able to reuse SPI_WIDTH.
REQ-029 The tick generator SHALL be a sub-module spi_clk_div (inputs CLK, RESET, clear; output tick; parameter CLK_DIV).

Verification (CLK_DIV=2 unless stated)
REQ-030 RESET high for 3 cycles mid-idle -> SS=1, SCLK=0, MOSI=0, busy=0, data_valid=0, received_data=0x00.
REQ-031 MOSI looped to MISO, start with 0xA5 -> SS low 36 cycles, 8 SCLK rises, MOSI bits 1,0,1,0,0,1,0,1 stable at each rise, received_data=0xA5, one data_valid pulse.
REQ-032 Behavioral mode-0 slave returning 0x3C while master sends 0xC3 -> slave captures 0xC3, received_data=0x3C.
REQ-033 start pulsed again mid-XFER with a different byte -> ignored; exactly one transfer and one data_valid pulse.
REQ-034 RESET for 1 cycle at the 4th SCLK rise -> next cycle SS=1, SCLK=0, no data_valid; a following 0x5A loopback transfer returns 0x5A.
REQ-035 CLK_DIV=1, start held high for 2 transfers -> SS high exactly 2 cycles between transfers, 2 data_valid pulses, 18-cycle SS-low windows.
